// File: rtl/seg7_scan_driver.sv
// Scans a latched 32-bit word as 8 hex digits onto a common-anode 7-segment bank,
// with an all-off gap between digits and optional leading-zero blanking (macro SEG7_BLINK_EN adds blink).
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 16,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        value_valid,
  input  logic        hold,
`ifdef SEG7_BLINK_EN
  input  logic        blink,
`endif
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n,
  output logic        frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic {DRIVE, GAP} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]  digit_q, digit_nxt;
  logic        tick_nxt;
  logic [31:0] shown_q;
  logic [31:0] upper;
  logic [3:0]  nibble;
  logic        blank;
  logic [7:0]  an_nxt, seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Loads are independent of the scan; they only change what the current slot shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_q <= 32'd0;
    end else if (value_valid && !hold) begin
      shown_q <= value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DRIVE;
      cnt     <= '0;
      digit_q <= 3'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      digit_q <= digit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    digit_nxt = digit_q;
    tick_nxt  = 1'b0;
    case (state)
      DRIVE: begin
        if (cnt == DRIVE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          digit_nxt = digit_q + 3'd1;
          state_nxt = DRIVE;
          tick_nxt  = (digit_q == 3'd7);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = DRIVE;
      end
    endcase
  end

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    upper  = shown_q >> {digit_q, 2'b00};
    nibble = upper[3:0];
    blank  = (BLANK_LZ != 0) && (digit_q != 3'd0) && (upper == 32'd0);
    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (state == DRIVE) begin
      seg_nxt = {1'b1, hex7(nibble)};
      if (!blank) begin
        an_nxt = ~(8'b1 << digit_q);
      end
    end
  end

`ifdef SEG7_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 5'd0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= 8'hFF;
      seg_n      <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= (blink && frame_cnt[4]) ? 8'hFF : an_nxt;
      seg_n      <= seg_nxt;
      frame_tick <= tick_nxt;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n       <= 8'hFF;
      seg_n      <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= an_nxt;
      seg_n      <= seg_nxt;
      frame_tick <= tick_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking on/off) checked every cycle against a
// frame-position model, plus literal frame patterns from hand-worked examples.
module tb_seg7_scan_driver;

  localparam int RD   = 4;
  localparam int GC   = 1;
  localparam int SLOT = RD + GC;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'd0;
  logic        value_valid = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  an_n, seg_n, an_nb, seg_nb;
  logic        frame_tick, tick_nb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(RD), .GAP_CYCLES(GC), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .hold(hold),
`ifdef SEG7_BLINK_EN
    .blink(1'b0),
`endif
    .an_n(an_n), .seg_n(seg_n), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD), .GAP_CYCLES(GC), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid), .hold(hold),
`ifdef SEG7_BLINK_EN
    .blink(1'b0),
`endif
    .an_n(an_nb), .seg_n(seg_nb), .frame_tick(tick_nb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame is just the edge count since reset modulo the frame length.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_edges = 0;
  logic [31:0] m_shown = 32'd0;
  logic [7:0]  e_an = 8'hFF, e_seg = 8'hFF, e_an_nb = 8'hFF, e_seg_nb = 8'hFF;
  logic        e_tick = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0; m_shown = 32'd0;
      e_an = 8'hFF; e_seg = 8'hFF; e_an_nb = 8'hFF; e_seg_nb = 8'hFF; e_tick = 1'b0;
    end else begin
      int pos, k, sig;
      logic [3:0] nib;
      pos = m_edges % FRAME;
      k   = pos / SLOT;
      sig = 1;
      for (int j = 1; j < 8; j++) if (((m_shown >> (4 * j)) & 32'hF) != 0) sig = j + 1;
      nib = 4'((m_shown >> (4 * k)) & 32'hF);
      if ((pos % SLOT) >= RD) begin
        e_an = 8'hFF; e_seg = 8'hFF; e_an_nb = 8'hFF; e_seg_nb = 8'hFF;
      end else begin
        e_an_nb  = ~(8'd1 << k);
        e_an     = (k < sig) ? e_an_nb : 8'hFF;
        e_seg    = {1'b1, hex_tab[nib]};
        e_seg_nb = e_seg;
      end
      e_tick = (pos == FRAME - 1);
      if (value_valid && !hold) m_shown = value;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    chk("an_n", {24'd0, an_n}, {24'd0, e_an});
    chk("seg_n", {24'd0, seg_n}, {24'd0, e_seg});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_tick});
    chk("nb_an_n", {24'd0, an_nb}, {24'd0, e_an_nb});
    chk("nb_seg_n", {24'd0, seg_nb}, {24'd0, e_seg_nb});
    chk("nb_frame_tick", {31'd0, tick_nb}, {31'd0, e_tick});
  end

  task automatic wait_tick();
    int i;
    for (i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) break;
    end
    chk("frame_tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic load(input logic [31:0] v, input logic h);
    @(negedge clk);
    value = v; value_valid = 1'b1; hold = h;
    @(negedge clk);
    value_valid = 1'b0; hold = 1'b0;
  endtask

  // Literal frame: byte k of each vector is digit k; dut seg is skipped where its anode is dark.
  task automatic check_frame(input string tag, input logic [63:0] an_exp,
                             input logic [63:0] seg_exp, input logic [63:0] seg_nb_exp);
    logic [63:0] an_all;
    an_all = 64'h7FBFDFEFF7FBFDFE;
    wait_tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("%s_d%0d_an", tag, k), {24'd0, an_n}, {24'd0, an_exp[8*k +: 8]});
      if (an_exp[8*k +: 8] != 8'hFF)
        chk($sformatf("%s_d%0d_seg", tag, k), {24'd0, seg_n}, {24'd0, seg_exp[8*k +: 8]});
      chk($sformatf("%s_d%0d_nb_an", tag, k), {24'd0, an_nb}, {24'd0, an_all[8*k +: 8]});
      chk($sformatf("%s_d%0d_nb_seg", tag, k), {24'd0, seg_nb}, {24'd0, seg_nb_exp[8*k +: 8]});
      repeat (RD - 1) @(negedge clk);
      @(negedge clk);
      chk($sformatf("%s_d%0d_gap", tag, k), {16'd0, an_n, seg_n}, 32'h0000FFFF);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", {24'd0, an_n}, 32'hFF);
    chk("reset_seg", {24'd0, seg_n}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_slot", {16'd0, an_n, seg_n}, 32'h0000FEC0);
    check_frame("zero", 64'hFFFFFFFFFFFFFFFE, 64'hC0C0C0C0C0C0C0C0, 64'hC0C0C0C0C0C0C0C0);

    load(32'h1234ABCF, 1'b0);
    check_frame("w1234", 64'h7FBFDFEFF7FBFDFE, 64'hF9A4B09988_83C68E, 64'hF9A4B09988_83C68E);

    load(32'h00000F00, 1'b0);
    check_frame("wF00", 64'hFFFFFFFFFFFBFDFE, 64'hC0C0C0C0C08EC0C0, 64'hC0C0C0C0C08EC0C0);

    @(negedge clk);
    value = 32'hFFFFFFFF; value_valid = 1'b1; hold = 1'b1;
    repeat (3) @(negedge clk);
    value_valid = 1'b0; hold = 1'b0;
    check_frame("held", 64'hFFFFFFFFFFFBFDFE, 64'hC0C0C0C0C08EC0C0, 64'hC0C0C0C0C08EC0C0);

    wait_tick();
    @(negedge clk);
    value = 32'hFFFFFFFF; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk("load_edge_seg", {24'd0, seg_n}, 32'hC0);
    @(negedge clk);
    chk("load_plus1", {16'd0, an_n, seg_n}, 32'h0000FE8E);
    check_frame("wFFFF", 64'h7FBFDFEFF7FBFDFE, 64'h8E8E8E8E8E8E8E8E, 64'h8E8E8E8E8E8E8E8E);

    wait_tick();
    repeat (5 * SLOT + 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {15'd0, frame_tick, an_n, seg_n}, 32'h0000FFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart", {16'd0, an_n, seg_n}, 32'h0000FEC0);
    check_frame("post_rst", 64'hFFFFFFFFFFFFFFFE, 64'hC0C0C0C0C0C0C0C0, 64'hC0C0C0C0C0C0C0C0);

    load(32'h80000000, 1'b0);
    load(32'h00010000, 1'b0);
    repeat (FRAME + 10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
